jtopl_eg_env: RTL and testbench
===============================

# jtopl_eg_env

Time-multiplexed ADSR envelope generator for the OPL operator pipeline. It owns per-slot envelope state (phase, attenuation, previous key-on) for `SLOTS` operator slots and processes one slot per `cen`. It produces the raw 10-bit envelope attenuation `eg_pure` that the downstream final-attenuation stage combines with TL, KSL and AM. It sources the slot index that upstream register banks use to present that slot's parameters.

## Interface
- `SLOTS`, 18, number of operator slots served round-robin (2..32).
- `rst`  in  1  asynchronous, active-high reset.
- `clk`  in  1  system clock.
- `cen`  in  1  clock enable; one slot is processed per cycle with `cen=1`.
- `slot`  out  5  slot whose parameters must be presented this cycle.
- `keyon`  in  1  key-on for `slot`.
- `ar`, `dr`, `rr`  in  4 each  attack, decay and release rates for `slot`.
- `sl`  in  4  sustain level for `slot`.
- `en_sus`  in  1  EG type: 1 holds in sustain, 0 keeps releasing at `rr`.
- `ksr`  in  1  key-scale-rate select.
- `keycode`  in  4  {block, fnum MSB} for `slot`.
- `eg_pure`  out  10  attenuation of `eg_slot`; 0 = loudest, 0x3FF = silent.
- `eg_slot`  out  5  slot index matching `eg_pure`.
- `eg_valid`  out  1  one-clock strobe: `eg_pure`/`eg_slot` updated.

## Operation
- Slot counter `slot`: increments on `cen`. It wraps `SLOTS-1`→0.
- Global 15-bit `eg_cnt`: increments on the `cen` where `slot` wraps. The wrapped modulo 2^15. Slot `SLOTS-1` processing on that cycle uses the old value.
- Phases: ATTACK, DECAY, SUSTAIN, RELEASE (2 bits per slot).
- Key edges use the stored per-slot `prev_keyon`:
  - Rising edge: enter ATTACK.
  - Falling edge: enter RELEASE from any phase.
  - Rising edge has priority over the same-cycle phase transition.
- Active rate r per phase: ATTACK `ar`; DECAY `dr`; SUSTAIN `en_sus ? 0 : rr`; RELEASE `rr`.
- Effective rate, 6 bits: 0 if r=0, else `{r,2'b0} + (ksr ? keycode : keycode>>2)`, saturated at 63.
  - base = rate[5:2]
  - Rate bits [1:0] are unused beyond the sum.
- Step qualification:
  - base 0: never steps.
  - base 1..12: steps when `eg_cnt[shift-1:0]==0`, shift = 13-base; inc = 1.
  - base 13/14/15: steps every visit; inc = 2/4/8.
- ATTACK update:
  - Effective rate ≥60 on the key-on edge: attn←0, phase←DECAY in that same visit.
  - Otherwise, when stepping: attn ← attn − ((attn>>3)+1)·inc. The subtraction uses 14-bit arithmetic and clamps at 0.
  - attn==0 at visit start → DECAY.
- DECAY/SUSTAIN/RELEASE update, when stepping: attn ← min(attn+inc, 0x3FF).
- DECAY→SUSTAIN when attn ≥ sl_attn, evaluated on the post-update value.
  - sl_attn = `{1'b0,sl,5'b0}` for sl<15.
  - sl_attn = 0x3E0 for sl=15.
- A phase change takes effect from the slot's next visit. Rate selection always uses the phase held at visit start; the key-on-edge case is the exception.

## Timing
- Reset values:
  - Every slot: attn=0x3FF, phase RELEASE, `prev_keyon=0`.
  - `eg_cnt=0`, `slot=0`.
  - `eg_pure=0x3FF`, `eg_slot=0`, `eg_valid=0`.
- Inputs are sampled on the rising edge where `cen=1`, for the current `slot`.
- The updated attenuation appears on `eg_pure` with `eg_slot` = that slot after the same edge. Latency is 1 clock.
- `eg_valid` is high for the clock following every `cen` edge. Outputs hold otherwise.
- With `cen=0`: no state, counter or output changes, except `eg_valid`, which drops.
- Reset asserted mid-sequence: all state returns to reset values immediately. Processing resumes at slot 0 on the first `cen` after release.
- A full slot revolution takes `SLOTS` `cen` cycles. A slot's own result is available `SLOTS` `cen` cycles after its previous update.

## Test plan
- Reset: assert `rst` mid-run with slot 5 at attn 0x100 → all outputs at reset values asynchronously. After release, the first `cen` gives `eg_slot=0`, `eg_pure=0x3FF`, `eg_valid=1` next clock.
- Instant attack: slot 0, `ar=15`, `ksr=1`, `keycode=0`, keyon 0→1 → `eg_pure=0x000` on that slot's first visit; DECAY entered.
- Decay to sustain: `dr=15`, `keycode=15`, `ksr=1`, `sl=2` → attn +8 per visit. `eg_pure` reaches ≥0x040 at visit 8 and then holds (`en_sus=1`).
- Release and saturation: keyon 1→0 with `rr=15`, `keycode=15`, `ksr=1` from attn 0x3FC → 0x3FF next visit, then stays 0x3FF.
- Slow rate: `dr=1`, `keycode=0` → attn steps only on visits where `eg_cnt[11:0]==0`. Check exact step count over 2^13 revolutions.
- `cen` gating and wrap: toggle `cen` irregularly with `SLOTS=18` → `slot` sequence 0..17,0. `eg_cnt` increments once per wrap. No change while `cen=0`.

Source files
------------

// File: rtl/jtopl_eg_env.sv
// Time-multiplexed OPL ADSR envelope generator: one operator slot per cen,
// per-slot phase/attenuation/key state held in small register arrays.
module jtopl_eg_env #(
    parameter int SLOTS = 18
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    output logic [4:0] slot,
    input  logic       keyon,
    input  logic [3:0] ar,
    input  logic [3:0] dr,
    input  logic [3:0] rr,
    input  logic [3:0] sl,
    input  logic       en_sus,
    input  logic       ksr,
    input  logic [3:0] keycode,
    output logic [9:0] eg_pure,
    output logic [4:0] eg_slot,
    output logic       eg_valid
);

    // phase   | meaning
    // ATTACK  | attenuation falls exponentially towards 0
    // DECAY   | attenuation rises until the sustain level
    // SUSTAIN | holds (en_sus=1) or keeps rising at rr (en_sus=0)
    // RELEASE | attenuation rises at rr towards silence
    typedef enum logic [1:0] {ATTACK, DECAY, SUSTAIN, RELEASE} phase_t;

    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

    logic [9:0]  attn_q  [SLOTS];
    phase_t      phase_q [SLOTS];
    logic        prev_q  [SLOTS];
    logic [14:0] eg_cnt;

    logic [9:0]  cur_attn, nxt_attn, sl_attn, atk_attn, inc_attn;
    phase_t      cur_phase, nxt_phase;
    logic        cur_prev, rise, fall, step;
    logic [3:0]  rate_sel, kadd, base, shift, inc;
    logic [6:0]  rate_sum;
    logic [5:0]  eff;
    logic [14:0] mask;
    logic [13:0] dec14, atk_diff;
    logic [10:0] inc_sum;

    always_comb begin
        cur_attn  = attn_q[slot];
        cur_phase = phase_q[slot];
        cur_prev  = prev_q[slot];
        rise      = keyon & ~cur_prev;
        fall      = ~keyon & cur_prev;

        // the key-on edge is the only case where rate ignores the stored phase
        case (cur_phase)
            ATTACK:  rate_sel = ar;
            DECAY:   rate_sel = dr;
            SUSTAIN: rate_sel = en_sus ? 4'd0 : rr;
            default: rate_sel = rr;
        endcase
        if (rise) rate_sel = ar;

        kadd     = ksr ? keycode : {2'b00, keycode[3:2]};
        rate_sum = {1'b0, rate_sel, 2'b00} + {3'b000, kadd};
        if (rate_sel == 4'd0)
            eff = 6'd0;
        else if (rate_sum > 7'd63)
            eff = 6'd63;
        else
            eff = rate_sum[5:0];

        base  = eff[5:2];
        shift = 4'd13 - base;
        mask  = (15'd1 << shift) - 15'd1;
        step  = 1'b0;
        inc   = 4'd1;
        case (base)
            4'd0:    step = 1'b0;
            4'd13:   begin step = 1'b1; inc = 4'd2; end
            4'd14:   begin step = 1'b1; inc = 4'd4; end
            4'd15:   begin step = 1'b1; inc = 4'd8; end
            default: step = ((eg_cnt & mask) == 15'd0);
        endcase

        dec14    = (14'(cur_attn >> 3) + 14'd1) * {10'd0, inc};
        atk_diff = {4'd0, cur_attn} - dec14;
        atk_attn = atk_diff[13] ? 10'd0 : atk_diff[9:0];
        inc_sum  = {1'b0, cur_attn} + {7'd0, inc};
        inc_attn = inc_sum[10] ? 10'h3FF : inc_sum[9:0];
        sl_attn  = (sl == 4'd15) ? 10'h3E0 : {1'b0, sl, 5'b0};

        nxt_attn  = cur_attn;
        nxt_phase = cur_phase;
        if (rise) begin
            if (eff >= 6'd60) begin
                nxt_attn  = 10'd0;
                nxt_phase = DECAY;
            end else begin
                if (step) nxt_attn = atk_attn;
                nxt_phase = ATTACK;
            end
        end else begin
            case (cur_phase)
                ATTACK: begin
                    if (cur_attn == 10'd0) nxt_phase = DECAY;
                    else if (step)         nxt_attn  = atk_attn;
                end
                DECAY: begin
                    if (step) nxt_attn = inc_attn;
                    if (nxt_attn >= sl_attn) nxt_phase = SUSTAIN;
                end
                default: begin
                    if (step) nxt_attn = inc_attn;
                end
            endcase
            if (fall) nxt_phase = RELEASE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                attn_q[i]  <= 10'h3FF;
                phase_q[i] <= RELEASE;
                prev_q[i]  <= 1'b0;
            end
            slot     <= 5'd0;
            eg_cnt   <= 15'd0;
            eg_pure  <= 10'h3FF;
            eg_slot  <= 5'd0;
            eg_valid <= 1'b0;
        end else begin
            eg_valid <= cen;
            if (cen) begin
                attn_q[slot]  <= nxt_attn;
                phase_q[slot] <= nxt_phase;
                prev_q[slot]  <= keyon;
                eg_pure       <= nxt_attn;
                eg_slot       <= slot;
                if (slot == LAST_SLOT) begin
                    slot   <= 5'd0;
                    eg_cnt <= eg_cnt + 15'd1;
                end else begin
                    slot <= slot + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtopl_eg_env.sv
// Self-checking bench for jtopl_eg_env: directed envelope scenarios on slot 0,
// randomized traffic on the other slots, all checked against an integer model.
module tb_jtopl_eg_env;

    localparam int SLOTS = 18;
    localparam int PA = 0, PD = 1, PS = 2, PR = 3;

    logic       rst, clk, cen, keyon, en_sus, ksr, eg_valid;
    logic [3:0] ar, dr, rr, sl, keycode;
    logic [4:0] slot, eg_slot;
    logic [9:0] eg_pure;

    jtopl_eg_env #(.SLOTS(SLOTS)) dut (
        .rst(rst), .clk(clk), .cen(cen), .slot(slot), .keyon(keyon),
        .ar(ar), .dr(dr), .rr(rr), .sl(sl), .en_sus(en_sus), .ksr(ksr),
        .keycode(keycode), .eg_pure(eg_pure), .eg_slot(eg_slot), .eg_valid(eg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // per-slot parameters presented whenever the model says that slot is up
    bit p_keyon [SLOTS];
    bit p_sus   [SLOTS];
    bit p_ksr   [SLOTS];
    int p_ar [SLOTS], p_dr [SLOTS], p_rr [SLOTS], p_sl [SLOTS], p_kc [SLOTS];

    int m_attn [SLOTS];
    int m_phase[SLOTS];
    bit m_prev [SLOTS];
    int m_cnt, m_slot, exp_pure, exp_eslot;

    task automatic chk(string tag, logic [31:0] obs, int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SLOTS; s++) begin
            m_attn[s] = 1023; m_phase[s] = PR; m_prev[s] = 0;
        end
        m_cnt = 0; m_slot = 0; exp_pure = 1023; exp_eslot = 0;
    endtask

    task automatic randomize_slot(int s);
        p_keyon[s] = $urandom_range(1); p_sus[s] = $urandom_range(1);
        p_ksr[s] = $urandom_range(1);   p_ar[s] = $urandom_range(15);
        p_dr[s] = $urandom_range(15);   p_rr[s] = $urandom_range(15);
        p_sl[s] = $urandom_range(15);   p_kc[s] = $urandom_range(15);
    endtask

    function automatic int attack_step(int a, int inc);
        int v = a - ((a / 8) + 1) * inc;
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model_visit();
        int s = m_slot;
        int a = m_attn[s];
        int ph = m_phase[s];
        int nph, r, e, b, inc, sl_lvl;
        bit st, rise, fall;
        rise = p_keyon[s] && !m_prev[s];
        fall = !p_keyon[s] && m_prev[s];
        if (rise)          r = p_ar[s];
        else if (ph == PA) r = p_ar[s];
        else if (ph == PD) r = p_dr[s];
        else if (ph == PS) r = p_sus[s] ? 0 : p_rr[s];
        else               r = p_rr[s];
        if (r == 0) e = 0;
        else begin
            e = 4 * r + (p_ksr[s] ? p_kc[s] : p_kc[s] / 4);
            if (e > 63) e = 63;
        end
        b   = e / 4;
        st  = (b == 0) ? 0 : (b <= 12) ? ((m_cnt % (1 << (13 - b))) == 0) : 1;
        inc = (b >= 13) ? (1 << (b - 12)) : 1;
        sl_lvl = (p_sl[s] == 15) ? 992 : p_sl[s] * 32;
        nph = ph;
        if (rise) begin
            if (e >= 60) begin a = 0; nph = PD; end
            else begin if (st) a = attack_step(a, inc); nph = PA; end
        end else begin
            if (ph == PA) begin
                if (a == 0) nph = PD;
                else if (st) a = attack_step(a, inc);
            end else begin
                if (st) a = (a + inc > 1023) ? 1023 : a + inc;
                if (ph == PD && a >= sl_lvl) nph = PS;
            end
            if (fall) nph = PR;
        end
        m_attn[s] = a; m_phase[s] = nph; m_prev[s] = p_keyon[s];
        exp_pure = a; exp_eslot = s;
        if (s == SLOTS - 1) begin
            m_slot = 0;
            m_cnt  = (m_cnt + 1) % 32768;
        end else begin
            m_slot = s + 1;
        end
    endtask

    task automatic cyc(bit c);
        @(negedge clk);
        if (c && m_slot != 0 && $urandom_range(7) == 0) randomize_slot(m_slot);
        cen = c;
        keyon = p_keyon[m_slot]; ar = 4'(p_ar[m_slot]); dr = 4'(p_dr[m_slot]);
        rr = 4'(p_rr[m_slot]); sl = 4'(p_sl[m_slot]); en_sus = p_sus[m_slot];
        ksr = p_ksr[m_slot]; keycode = 4'(p_kc[m_slot]);
        @(posedge clk);
        #1;
        if (c) model_visit();
        chk("slot", slot, m_slot);
        chk("eg_valid", eg_valid, int'(c));
        chk("eg_pure", eg_pure, exp_pure);
        chk("eg_slot", eg_slot, exp_eslot);
    endtask

    // runs cen cycles (with random idle gaps) up to and including slot 0's visit
    task automatic visit0();
        bit done = 0;
        for (int i = 0; i < 2 * SLOTS && !done; i++) begin
            if ($urandom_range(3) == 0) cyc(0);
            if (m_slot == 0) done = 1;
            cyc(1);
        end
        chk("visit0_bound", done, 1);
    endtask

    task automatic set0(bit k, int a, int d, int r, int s, bit sus, bit ks, int kc);
        p_keyon[0] = k; p_ar[0] = a; p_dr[0] = d; p_rr[0] = r;
        p_sl[0] = s; p_sus[0] = sus; p_ksr[0] = ks; p_kc[0] = kc;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_slot"}, slot, 0);
        chk({tag, "_eg_pure"}, eg_pure, 10'h3FF);
        chk({tag, "_eg_slot"}, eg_slot, 0);
        chk({tag, "_eg_valid"}, eg_valid, 0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; keyon = 1'b0; ar = '0; dr = '0; rr = '0;
        sl = '0; en_sus = 1'b0; ksr = 1'b0; keycode = '0;
        for (int s = 0; s < SLOTS; s++) randomize_slot(s);
        set0(0, 0, 0, 0, 0, 1, 0, 0);
        model_reset();
        #23;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // first visit after reset: slot 0 silent
        visit0();
        chk("first_eg_slot", eg_slot, 0);
        chk("first_eg_pure", eg_pure, 10'h3FF);

        // instant attack: eff rate 60 jumps to 0
        set0(1, 15, 0, 0, 0, 1, 1, 0);
        visit0();
        chk("instant_attack", eg_pure, 0);

        // fast decay +8 per visit up to sustain level 0x40, then hold
        set0(1, 15, 15, 0, 2, 1, 1, 15);
        for (int k = 1; k <= 8; k++) begin
            visit0();
            chk("decay_step", eg_pure, 8 * k);
        end
        for (int k = 0; k < 3; k++) begin
            visit0();
            chk("sustain_hold", eg_pure, 10'h040);
        end

        // sustain without hold rises +4 per visit to 0x3FC
        set0(1, 15, 15, 14, 2, 0, 1, 0);
        for (int k = 0; k < 239; k++) visit0();
        chk("sustain_rise", eg_pure, 10'h3FC);

        // key-off: release phase takes effect next visit, then saturates
        set0(0, 15, 15, 15, 2, 1, 1, 15);
        visit0();
        chk("keyoff_visit", eg_pure, 10'h3FC);
        visit0();
        chk("release_sat", eg_pure, 10'h3FF);
        visit0();
        chk("release_hold", eg_pure, 10'h3FF);

        // slow decay: base 5 steps once per 256 eg_cnt values
        set0(1, 15, 0, 0, 15, 1, 1, 2);
        visit0();
        chk("reattack", eg_pure, 0);
        set0(1, 15, 2, 0, 15, 1, 1, 15);
        for (int k = 0; k < 1024; k++) visit0();
        chk("slow_steps", eg_pure, 4);

        // random traffic on every slot including slot 0
        randomize_slot(0);
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(3) == 0) randomize_slot(0);
            visit0();
        end
        for (int k = 0; k < 7; k++) cyc($urandom_range(1));

        // asynchronous reset in the middle of a revolution
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set0(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0);
        cyc(1);
        chk("post_rst_eg_slot", eg_slot, 0);
        chk("post_rst_eg_pure", eg_pure, 10'h3FF);
        for (int k = 0; k < 3 * SLOTS; k++) cyc($urandom_range(3) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
